// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: engine sizing constants,
// sequencer state encoding and instruction-word field layout.
package instr_sequencer_pkg;

  // Engine-wide sizing (shared with the rest of the MAC engine).
  localparam int BIT_WIDTH                 = 32;
  localparam int INSTRUCTION_MEMORY_FIELDS = 8;
  localparam int INSTRUCTION_MEMORY_SIZE   = 2;

  // Repeat counter width.
  localparam int REP_W = 16;

  // Field indices inside an instruction word.
  localparam int FLD_CTRL = 0;
  localparam int FLD_REP  = 1;

  // Bit positions inside the control field.
  localparam int LAST_BIT = 0;
  localparam int NOP_BIT  = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_perf_counters.sv
// Saturating performance counters for the instruction sequencer.
// Only compiled when SEQ_PERF_COUNTERS_EN is defined.
`ifdef SEQ_PERF_COUNTERS_EN
module seq_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] busy_cycles,
  output logic [31:0] stall_cycles
);

  // Count busy cycles, saturating at all-ones; cleared by reset or clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cycles <= 32'd0;
    end else if (clr) begin
      busy_cycles <= 32'd0;
    end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end else begin
      busy_cycles <= busy_cycles;
    end
  end

  // Count issue cycles stalled by the consumer, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
    end else if (clr) begin
      stall_cycles <= 32'd0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule
`endif

// File: rtl/instr_sequencer.sv
// Program sequencer for the MAC engine: fetches instruction words by PC,
// issues them over valid/ready, waits for layer completion, and handles
// repeats, NOP skip, LAST termination, PC overrun and abort.
// Optional macro SEQ_PERF_COUNTERS_EN adds busy/stall cycle counters.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int NUM_FIELDS = INSTRUCTION_MEMORY_FIELDS,
  parameter int FIELD_W    = BIT_WIDTH,
  parameter int IM_SIZE    = INSTRUCTION_MEMORY_SIZE,
  parameter int REP_W      = instr_sequencer_pkg::REP_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_FIELDS*FIELD_W-1:0] instruction,
  output logic [31:0]                   PC,
  output logic [NUM_FIELDS*FIELD_W-1:0] instr_out,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          layer_done,
  output logic [REP_W-1:0]              rep_idx,
  output logic                          busy,
  output logic                          program_done,
  output logic                          pc_oob_err
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  input  logic                          perf_clr,
  output logic [31:0]                   perf_busy_cycles,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  localparam int WORD_W = NUM_FIELDS * FIELD_W;

  seq_state_e        state;
  seq_state_e        state_nxt;
  logic [31:0]       pc_nxt;
  logic [WORD_W-1:0] instr_out_nxt;
  logic              valid_nxt;
  logic [REP_W-1:0]  rep_nxt;
  logic              oob_nxt;
  logic              done_nxt;
  logic              advance;
  logic              adv_last;

  // Decode of the freshly fetched word (used in FETCH) and of the held word.
  logic              fetch_last;
  logic              fetch_nop;
  logic              held_last;
  logic [REP_W-1:0]  rep_field;
  logic [REP_W:0]    rep_target;
  logic [REP_W:0]    rep_plus_one;
  logic              pc_at_end;

  assign fetch_last   = instruction[FLD_CTRL*FIELD_W + LAST_BIT];
  assign fetch_nop    = instruction[FLD_CTRL*FIELD_W + NOP_BIT];
  assign held_last    = instr_out[FLD_CTRL*FIELD_W + LAST_BIT];
  assign rep_field    = instr_out[FLD_REP*FIELD_W +: REP_W];
  // A repeat count of zero still executes the instruction once.
  assign rep_target   = (rep_field == {REP_W{1'b0}}) ? {{REP_W{1'b0}}, 1'b1}
                                                     : {1'b0, rep_field};
  assign rep_plus_one = {1'b0, rep_idx} + {{REP_W{1'b0}}, 1'b1};
  assign pc_at_end    = (({1'b0, PC} + 33'd1) >= 33'(IM_SIZE));

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = PC;
    instr_out_nxt = instr_out;
    valid_nxt     = instr_valid;
    rep_nxt       = rep_idx;
    oob_nxt       = pc_oob_err;
    advance       = 1'b0;
    adv_last      = 1'b0;

    if (abort) begin
      state_nxt = ST_IDLE;
      valid_nxt = 1'b0;
      pc_nxt    = 32'd0;
      rep_nxt   = {REP_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_FETCH;
            pc_nxt    = 32'd0;
            oob_nxt   = 1'b0;
            rep_nxt   = {REP_W{1'b0}};
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_FETCH: begin
          instr_out_nxt = instruction;
          if (fetch_nop) begin
            advance  = 1'b1;
            adv_last = fetch_last;
          end else begin
            state_nxt = ST_ISSUE;
            valid_nxt = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            valid_nxt = 1'b0;
            state_nxt = ST_WAIT_DONE;
          end else begin
            valid_nxt = 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (layer_done) begin
            if (rep_plus_one < rep_target) begin
              rep_nxt   = rep_plus_one[REP_W-1:0];
              state_nxt = ST_ISSUE;
              valid_nxt = 1'b1;
            end else begin
              advance  = 1'b1;
              adv_last = held_last;
            end
          end else begin
            state_nxt = ST_WAIT_DONE;
          end
        end
        ST_FINISH: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
        end
      endcase

      // Shared advance path from FETCH (NOP) and WAIT_DONE (last repeat).
      if (advance) begin
        if (adv_last) begin
          state_nxt = ST_FINISH;
        end else if (pc_at_end) begin
          oob_nxt   = 1'b1;
          state_nxt = ST_FINISH;
        end else begin
          pc_nxt    = PC + 32'd1;
          rep_nxt   = {REP_W{1'b0}};
          state_nxt = ST_FETCH;
        end
      end else begin
        adv_last = 1'b0;
      end
    end

    // program_done is high for exactly the FINISH cycle of a clean run.
    done_nxt = (state_nxt == ST_FINISH) && !oob_nxt;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      PC           <= 32'd0;
      instr_out    <= {WORD_W{1'b0}};
      instr_valid  <= 1'b0;
      rep_idx      <= {REP_W{1'b0}};
      busy         <= 1'b0;
      program_done <= 1'b0;
      pc_oob_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      PC           <= pc_nxt;
      instr_out    <= instr_out_nxt;
      instr_valid  <= valid_nxt;
      rep_idx      <= rep_nxt;
      busy         <= (state_nxt != ST_IDLE);
      program_done <= done_nxt;
      pc_oob_err   <= oob_nxt;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic issue_stall;
  assign issue_stall = (state == ST_ISSUE) && !instr_ready;

  seq_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .clr          (perf_clr),
    .busy         (busy),
    .stall        (issue_stall),
    .busy_cycles  (perf_busy_cycles),
    .stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven programs, randomized
// programs against a behavioural program model, and hand-written corner cases.
module tb_instr_sequencer;

  localparam int WORD_W = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              instr_ready = 1'b0;
  logic              layer_done = 1'b0;
  logic [WORD_W-1:0] instruction;
  logic [31:0]       PC;
  logic [WORD_W-1:0] instr_out;
  logic              instr_valid;
  logic [15:0]       rep_idx;
  logic              busy;
  logic              program_done;
  logic              pc_oob_err;
`ifdef SEQ_PERF_COUNTERS_EN
  logic              perf_clr = 1'b0;
  logic [31:0]       perf_busy_cycles;
  logic [31:0]       perf_stall_cycles;
`endif

  logic [WORD_W-1:0] mem [0:1];
  int total = 0;
  int bad = 0;

  instr_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .instruction  (instruction),
    .PC           (PC),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .layer_done   (layer_done),
    .rep_idx      (rep_idx),
    .busy         (busy),
    .program_done (program_done),
    .pc_oob_err   (pc_oob_err)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .perf_clr          (perf_clr),
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range addresses read zero.
  assign instruction = (PC < 32'd2) ? mem[PC[0]] : {WORD_W{1'b0}};

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [WORD_W-1:0] act,
                           input logic [WORD_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input logic [31:0] c, input logic [31:0] r);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    w[31:0]  = c;
    w[63:32] = r;
    return w;
  endfunction

  // Behavioural program model: expected issue list and program outcome.
  typedef struct { int pc; int rep; } iss_t;
  iss_t exp_q[$];
  int   exp_done;
  int   exp_oob;
  int   exp_pc;

  task automatic model_run();
    int          p;
    int          n;
    logic [31:0] c;
    logic        idx;
    p = 0;
    exp_q.delete();
    exp_done = 0;
    exp_oob  = 0;
    while (1) begin
      idx = (p == 1);
      c = mem[idx][31:0];
      n = int'(mem[idx][47:32]);
      if (n == 0) n = 1;
      if (!c[1]) begin
        for (int r = 0; r < n; r++) exp_q.push_back('{p, r});
      end
      if (c[0]) begin
        exp_done = 1;
        break;
      end
      if (p + 1 >= 2) begin
        exp_oob = 1;
        break;
      end
      p++;
    end
    exp_pc = p;
  endtask

  // Run one program to completion with random backpressure and done delays,
  // comparing every issue against the model.
  task automatic run_prog(input int max_stall, output int n_iss, output int n_done);
    int   cyc;
    int   wait_cnt;
    int   stall_left;
    bit   pending;
    bit   prev_hold;
    logic [WORD_W-1:0] held;
    n_iss = 0;
    n_done = 0;
    pending = 0;
    prev_hold = 0;
    wait_cnt = 0;
    held = '0;
    stall_left = $urandom_range(0, max_stall);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 1000) begin
      if (program_done) n_done++;
      if (!busy) break;
      layer_done = 1'b0;
      if (pending) begin
        if (wait_cnt == 0) begin
          layer_done = 1'b1;
          pending = 0;
        end else begin
          wait_cnt--;
        end
      end
      instr_ready = 1'b0;
      if (instr_valid) begin
        if (prev_hold) check_vec("hold_stable", instr_out, held);
        if (stall_left > 0) begin
          stall_left--;
          held = instr_out;
          prev_hold = 1;
        end else begin
          instr_ready = 1'b1;
          prev_hold = 0;
          if (n_iss < exp_q.size()) begin
            check_int("issue_pc", int'(PC), exp_q[n_iss].pc);
            check_int("issue_rep", int'(rep_idx), exp_q[n_iss].rep);
            check_vec("issue_word", instr_out, mem[exp_q[n_iss].pc == 1]);
          end
          n_iss++;
          pending = 1;
          wait_cnt = $urandom_range(0, 4);
          stall_left = $urandom_range(0, max_stall);
        end
      end else begin
        prev_hold = 0;
      end
      @(negedge clk);
      cyc++;
    end
    layer_done = 1'b0;
    instr_ready = 1'b0;
    check_int("run_timeout", int'(cyc >= 1000), 0);
    check_int("model_issues", n_iss, exp_q.size());
    check_int("model_done", n_done, exp_done);
    check_int("model_oob", int'(pc_oob_err), exp_oob);
    check_int("model_pc", int'(PC), exp_pc);
    check_int("busy_end", int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_int(name, int'(instr_valid), 1);
  endtask

  task automatic wait_idle(output int n_done);
    int n;
    n = 0;
    n_done = 0;
    while (busy && n < 200) begin
      if (program_done) n_done++;
      @(negedge clk);
      n++;
    end
    check_int("idle_timeout", int'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_int({tag, "_pc"}, int'(PC), 0);
    check_vec({tag, "_instr"}, instr_out, {WORD_W{1'b0}});
    check_int({tag, "_valid"}, int'(instr_valid), 0);
    check_int({tag, "_rep"}, int'(rep_idx), 0);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_int({tag, "_done"}, int'(program_done), 0);
    check_int({tag, "_oob"}, int'(pc_oob_err), 0);
  endtask

  typedef struct {
    logic [31:0] c0;
    logic [31:0] r0;
    logic [31:0] c1;
    logic [31:0] r1;
    int          issues;
    int          done;
    int          oob;
    int          fpc;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   n_iss;
    int   n_done;

    // Hand-computed program outcomes.
    vecs[0] = '{32'h0, 32'd3, 32'h1, 32'd0, 4, 1, 0, 1};
    vecs[1] = '{32'h2, 32'd5, 32'h1, 32'd2, 2, 1, 0, 1};
    vecs[2] = '{32'h0, 32'd0, 32'h0, 32'd0, 2, 0, 1, 1};
    vecs[3] = '{32'h1, 32'd1, 32'h0, 32'd4, 1, 1, 0, 0};
    vecs[4] = '{32'h3, 32'd2, 32'h0, 32'd1, 0, 1, 0, 0};
    vecs[5] = '{32'h2, 32'd1, 32'h2, 32'd1, 0, 0, 1, 1};
    vecs[6] = '{32'h0, 32'd2, 32'h2, 32'd3, 2, 0, 1, 1};
    vecs[7] = '{32'h0, 32'h0001_0002, 32'hFFFF_FFF1, 32'd0, 3, 1, 0, 1};

    mem[0] = mk_word(32'h0, 32'd1);
    mem[1] = mk_word(32'h1, 32'd1);

    #3;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Table-driven programs.
    for (int i = 0; i < 8; i++) begin
      mem[0] = mk_word(vecs[i].c0, vecs[i].r0);
      mem[1] = mk_word(vecs[i].c1, vecs[i].r1);
      model_run();
      run_prog(3, n_iss, n_done);
      check_int($sformatf("tbl%0d_issues", i), n_iss, vecs[i].issues);
      check_int($sformatf("tbl%0d_done", i), n_done, vecs[i].done);
      check_int($sformatf("tbl%0d_oob", i), int'(pc_oob_err), vecs[i].oob);
      check_int($sformatf("tbl%0d_pc", i), int'(PC), vecs[i].fpc);
    end

    // Randomized programs against the model.
    for (int i = 0; i < 20; i++) begin
      mem[0] = mk_word($urandom, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4)));
      mem[1] = mk_word($urandom, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4)));
      model_run();
      run_prog(3, n_iss, n_done);
    end

    // Backpressure: ten cycles of instr_ready low while issuing.
    mem[0] = mk_word(32'h1, 32'd1);
    mem[1] = mk_word(32'h1, 32'd1);
`ifdef SEQ_PERF_COUNTERS_EN
    @(negedge clk);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    check_int("perf_clr_stall", int'(perf_stall_cycles), 0);
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      check_int("bp_valid_hold", int'(instr_valid), 1);
      check_vec("bp_word_hold", instr_out, mem[0]);
      @(negedge clk);
    end
`ifdef SEQ_PERF_COUNTERS_EN
    check_int("perf_stall10", int'(perf_stall_cycles), 10);
`endif
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
    wait_idle(n_done);
    check_int("bp_done", n_done, 1);

    // Abort while waiting for layer completion.
    mem[0] = mk_word(32'h0, 32'd2);
    mem[1] = mk_word(32'h1, 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("ab_valid");
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_int("ab_busy", int'(busy), 0);
    check_int("ab_pc", int'(PC), 0);
    check_int("ab_valid0", int'(instr_valid), 0);
    check_int("ab_rep", int'(rep_idx), 0);
    check_int("ab_nodone", int'(program_done), 0);
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
    @(negedge clk);
    check_int("ab_ld_ignored_busy", int'(busy), 0);
    check_int("ab_ld_ignored_valid", int'(instr_valid), 0);
    model_run();
    run_prog(2, n_iss, n_done);
    check_int("ab_restart_issues", n_iss, 3);

    // start while busy is ignored; async reset mid-issue clears everything.
    mem[0] = mk_word(32'h2, 32'd7);
    mem[1] = mk_word(32'h1, 32'd3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("sb_valid");
    check_int("sb_pc_first", int'(PC), 1);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    layer_done = 1'b1;
    @(negedge clk);
    layer_done = 1'b0;
    wait_valid("sb_valid2");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_int("sb_pc", int'(PC), 1);
    check_int("sb_rep", int'(rep_idx), 1);
    check_int("sb_valid_kept", int'(instr_valid), 1);
    check_int("sb_busy", int'(busy), 1);
    check_vec("sb_word", instr_out, mem[1]);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_int("post_rst_busy", int'(busy), 0);
    mem[0] = mk_word(32'h0, 32'd2);
    mem[1] = mk_word(32'h1, 32'd1);
    model_run();
    run_prog(1, n_iss, n_done);
    check_int("post_rst_issues", n_iss, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
